// File: rtl/farrow_pkg.sv
// Purpose: shared constants, mode type and width helper for the Farrow interpolator.
// Latency: n/a (package).
// Backpressure: n/a (package).
package farrow_pkg;

    localparam int FARROW_COEF_W    = 16;
    localparam int FARROW_COEF_FRAC = 14;

    // Lagrange matrix entries in Q.14: 1/6, 1/3, 1/2, 1
    localparam logic signed [FARROW_COEF_W-1:0] K6 = 16'sd2731;
    localparam logic signed [FARROW_COEF_W-1:0] K3 = 16'sd5461;
    localparam logic signed [FARROW_COEF_W-1:0] K2 = 16'sd8192;
    localparam logic signed [FARROW_COEF_W-1:0] K1 = 16'sd16384;

    typedef enum logic {FARROW_CUBIC = 1'b0, FARROW_LINEAR = 1'b1} farrow_mode_e;

    // Worst-case sum of |K|*|x| over all four polynomial terms stays below 2^(d+c+1).
    function automatic int acc_width(input int data_w, input int coef_w);
        return data_w + coef_w + 2;
    endfunction

endpackage

// File: rtl/farrow_interp_if.sv
// Purpose: sample-in / sample-out valid-ready bundle for farrow_interp.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready carry the stall in each direction.
// Ports: in_valid/in_ready/data_in/mu_in/mode_in (source side),
//        out_valid/out_ready/data_out/sat_out (sink side).
interface farrow_interp_if
    import farrow_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MU_W   = 16
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] data_in;
    logic        [MU_W-1:0]   mu_in;
    farrow_mode_e             mode_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] data_out;
    logic                     sat_out;

    modport master (
        output in_valid, data_in, mu_in, mode_in, out_ready,
        input  in_ready, out_valid, data_out, sat_out
    );

    modport slave (
        input  in_valid, data_in, mu_in, mode_in, out_ready,
        output in_ready, out_valid, data_out, sat_out
    );
endinterface

// File: rtl/farrow_horner_stage.sv
// Purpose: one Horner step h' = round(h*mu >> MU_W) + c[SEL], forwarding mu and coefficients.
// Latency: 1 cycle.
// Backpressure: holds all state while en is low; flush clears only the valid.
// Ports: en (advance), flush, vld/h/mu/coef in and registered out.
module farrow_horner_stage #(
    parameter int ACC_W = 34,
    parameter int MU_W  = 16,
    parameter int SEL   = 0      // which of {c2,c1,c0} this stage adds (2 = c2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    vld_in,
    input  logic signed [ACC_W-1:0] h_in,
    input  logic        [MU_W-1:0]  mu_in,
    input  logic      [3*ACC_W-1:0] coef_in,
    output logic                    vld_out,
    output logic signed [ACC_W-1:0] h_out,
    output logic        [MU_W-1:0]  mu_out,
    output logic      [3*ACC_W-1:0] coef_out
);
    localparam int P_W = ACC_W + MU_W + 1;
    localparam logic signed [P_W-1:0] RND = P_W'(1) << (MU_W - 1);

    logic signed [P_W-1:0]   prod;
    logic signed [P_W-1:0]   rnd;
    logic signed [ACC_W-1:0] c_sel;
    logic signed [ACC_W-1:0] h_nxt;

    always_comb begin
        // mu is a pure fraction, so |h*mu >> MU_W| <= |h| and truncation back to ACC_W is safe
        prod  = P_W'(h_in) * P_W'($signed({1'b0, mu_in}));
        rnd   = prod + RND;
        c_sel = coef_in[SEL*ACC_W +: ACC_W];
        h_nxt = ACC_W'(rnd >>> MU_W) + c_sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_out  <= 1'b0;
            h_out    <= '0;
            mu_out   <= '0;
            coef_out <= '0;
        end else begin
            if (en) begin
                vld_out  <= vld_in;
                h_out    <= h_nxt;
                mu_out   <= mu_in;
                coef_out <= coef_in;
            end
            if (flush) vld_out <= 1'b0;
        end
    end
endmodule

// File: rtl/farrow_interp.sv
// Purpose: cubic-Lagrange / linear Farrow fractional-delay interpolator.
// Latency: 5 cycles from accepting edge to out_valid when not stalled.
// Backpressure: whole pipeline freezes while out_valid & !out_ready; in_ready follows.
// Ports: clk, rst (async active-low), flush (sync clear), bus (farrow_interp_if.slave).
module farrow_interp
    import farrow_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MU_W      = 16,
    parameter int COEF_W    = FARROW_COEF_W,
    parameter int COEF_FRAC = FARROW_COEF_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    farrow_interp_if.slave   bus
);
    localparam int ACC_W = acc_width(DATA_W, COEF_W);
    localparam logic signed [ACC_W-1:0] OUT_RND = ACC_W'(1) << (COEF_FRAC - 1);
    localparam int HI_W = ACC_W - COEF_FRAC - DATA_W + 1;

    logic ready_en, adv, take;
    logic out_valid_q, sat_q;
    logic signed [DATA_W-1:0] data_q;

    // S0: tap history plus the sidebands of the newest sample
    logic signed [DATA_W-1:0] xm1, x0, x1, x2;
    logic [1:0]               prime;
    logic                     s0_vld;
    logic [MU_W-1:0]          s0_mu;
    farrow_mode_e             s0_mode;

    // S1: registered polynomial coefficients
    logic                     s1_vld;
    logic [MU_W-1:0]          s1_mu;
    logic signed [ACC_W-1:0]  s1_c3;
    logic [3*ACC_W-1:0]       s1_coef;
    logic signed [ACC_W-1:0]  em1, e0, e1, e2, c0_n, c1_n, c2_n, c3_n;

    logic                     s2_vld, s3_vld, s4_vld;
    logic signed [ACC_W-1:0]  s2_h, s3_h, s4_h;
    logic [MU_W-1:0]          s2_mu, s3_mu;
    logic [3*ACC_W-1:0]       s2_coef, s3_coef;

    logic signed [ACC_W-1:0]  y_rnd;
    logic                     y_ovf;
    logic signed [DATA_W-1:0] y_sat;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = ready_en && adv;
    // a sample offered during flush is dropped rather than landing in the cleared history
    assign take         = bus.in_valid && bus.in_ready && !flush;

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;
    assign bus.sat_out   = sat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {xm1, x0, x1, x2} <= '0;
            prime   <= '0;
            s0_vld  <= 1'b0;
            s0_mu   <= '0;
            s0_mode <= FARROW_CUBIC;
        end else if (flush) begin
            {xm1, x0, x1, x2} <= '0;
            prime   <= '0;
            s0_vld  <= 1'b0;
        end else begin
            // only the fourth and later samples see a full history
            if (adv) s0_vld <= take && (prime == 2'd3);
            if (take) begin
                xm1     <= x0;
                x0      <= x1;
                x1      <= x2;
                x2      <= bus.data_in;
                s0_mu   <= bus.mu_in;
                s0_mode <= bus.mode_in;
                if (prime != 2'd3) prime <= prime + 2'd1;
            end
        end
    end

    always_comb begin
        em1  = ACC_W'(xm1);
        e0   = ACC_W'(x0);
        e1   = ACC_W'(x1);
        e2   = ACC_W'(x2);
        c0_n = e0 <<< COEF_FRAC;
        if (s0_mode == FARROW_LINEAR) begin
            c3_n = '0;
            c2_n = '0;
            c1_n = ACC_W'(K1) * (e1 - e0);
        end else begin
            c1_n = -(ACC_W'(K3) * em1) - ACC_W'(K2) * e0 + ACC_W'(K1) * e1 - ACC_W'(K6) * e2;
            c2_n =   ACC_W'(K2) * em1  - ACC_W'(K1) * e0 + ACC_W'(K2) * e1;
            c3_n = -(ACC_W'(K6) * em1) + ACC_W'(K2) * e0 - ACC_W'(K2) * e1 + ACC_W'(K6) * e2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s1_mu   <= '0;
            s1_c3   <= '0;
            s1_coef <= '0;
        end else begin
            if (adv) begin
                s1_vld  <= s0_vld;
                s1_mu   <= s0_mu;
                s1_c3   <= c3_n;
                s1_coef <= {c2_n, c1_n, c0_n};
            end
            if (flush) s1_vld <= 1'b0;
        end
    end

    farrow_horner_stage #(.ACC_W(ACC_W), .MU_W(MU_W), .SEL(2)) u_s2 (
        .clk(clk), .rst(rst), .en(adv), .flush(flush),
        .vld_in(s1_vld), .h_in(s1_c3), .mu_in(s1_mu), .coef_in(s1_coef),
        .vld_out(s2_vld), .h_out(s2_h), .mu_out(s2_mu), .coef_out(s2_coef)
    );

    farrow_horner_stage #(.ACC_W(ACC_W), .MU_W(MU_W), .SEL(1)) u_s3 (
        .clk(clk), .rst(rst), .en(adv), .flush(flush),
        .vld_in(s2_vld), .h_in(s2_h), .mu_in(s2_mu), .coef_in(s2_coef),
        .vld_out(s3_vld), .h_out(s3_h), .mu_out(s3_mu), .coef_out(s3_coef)
    );

    farrow_horner_stage #(.ACC_W(ACC_W), .MU_W(MU_W), .SEL(0)) u_s4 (
        .clk(clk), .rst(rst), .en(adv), .flush(flush),
        .vld_in(s3_vld), .h_in(s3_h), .mu_in(s3_mu), .coef_in(s3_coef),
        .vld_out(s4_vld), .h_out(s4_h), .mu_out(), .coef_out()
    );

    // Round to integer, then clip: overflow whenever the bits above the output sign differ from it.
    always_comb begin
        y_rnd = s4_h + OUT_RND;
        y_ovf = (y_rnd[ACC_W-1 -: HI_W] != {HI_W{y_rnd[ACC_W-1]}});
        if (y_ovf) y_sat = y_rnd[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else       y_sat = y_rnd[COEF_FRAC +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            sat_q       <= 1'b0;
        end else begin
            if (adv) begin
                out_valid_q <= s4_vld;
                if (s4_vld) begin
                    data_q <= y_sat;
                    sat_q  <= y_ovf;
                end
            end
            if (flush) out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_farrow_interp.sv
// Purpose: directed self-checking bench for farrow_interp.
// Latency: n/a.
// Backpressure: bench drives out_ready and honours in_ready.
module tb_farrow_interp;
    import farrow_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    farrow_interp_if #(.DATA_W(16), .MU_W(16)) bus ();

    farrow_interp dut (.clk(clk), .rst(rst_n), .flush(flush), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int got_d[$];
    bit got_s[$];
    int exp_d[$];
    bit exp_s[$];

    longint mt[4];
    int     mprime;

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            got_d.push_back(int'(bus.data_out));
            got_s.push_back(bus.sat_out);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic void model_calc(input longint xm1, input longint x0, input longint x1,
                                       input longint x2, input longint mu, input bit lin,
                                       output int y, output bit s);
        longint c0, c1, c2, c3, h, r;
        c0 = x0 * 16384;
        if (lin) begin
            c3 = 0; c2 = 0; c1 = 16384 * (x1 - x0);
        end else begin
            c1 = -5461 * xm1 - 8192 * x0 + 16384 * x1 - 2731 * x2;
            c2 =  8192 * xm1 - 16384 * x0 + 8192 * x1;
            c3 = -2731 * xm1 + 8192 * x0 - 8192 * x1 + 2731 * x2;
        end
        h = c3;
        h = ((h * mu + 32768) >>> 16) + c2;
        h = ((h * mu + 32768) >>> 16) + c1;
        h = ((h * mu + 32768) >>> 16) + c0;
        r = (h + 8192) >>> 14;
        s = 1'b0;
        if (r > 32767) begin r = 32767; s = 1'b1; end
        else if (r < -32768) begin r = -32768; s = 1'b1; end
        y = int'(r);
    endfunction

    task automatic model_accept(input int d, input int m, input bit lin);
        int y; bit s;
        mt[0] = mt[1]; mt[1] = mt[2]; mt[2] = mt[3]; mt[3] = longint'(d);
        if (mprime == 3) begin
            model_calc(mt[0], mt[1], mt[2], mt[3], longint'(m), lin, y, s);
            exp_d.push_back(y);
            exp_s.push_back(s);
        end else begin
            mprime++;
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) mt[i] = 0;
        mprime = 0;
        got_d.delete(); got_s.delete(); exp_d.delete(); exp_s.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.data_in = '0; bus.mu_in = '0;
        bus.mode_in = FARROW_CUBIC; bus.out_ready = 1'b1;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_all();
    endtask

    task automatic send(input int d, input int m, input bit lin);
        int g;
        g = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.data_in  = 16'(d);
        bus.mu_in    = 16'(m);
        bus.mode_in  = lin ? FARROW_LINEAR : FARROW_CUBIC;
        while (!bus.in_ready && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", bus.in_ready);
        end else begin
            @(posedge clk);
            model_accept(d, m, lin);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input int extra);
        int g;
        g = 0;
        while (got_d.size() < n && g < 200) begin @(negedge clk); g++; end
        repeat (extra) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b, required 0", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid); end
        n_tests++; if (bus.data_out !== 16'sd0) begin n_fail++; $display("FAIL reset_data_out: got %0d, required 0", bus.data_out); end
        n_tests++; if (bus.sat_out !== 1'b0) begin n_fail++; $display("FAIL reset_sat_out: got %0b, required 0", bus.sat_out); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %0b, required 1", bus.in_ready); end
    endtask

    task automatic test_dc();
        do_reset();
        for (int i = 0; i < 8; i++) send(1000, int'($urandom_range(0, 65535)), 1'b0);
        idle();
        wait_outputs(5, 10);
        n_tests++; if (got_d.size() != 5) begin n_fail++; $display("FAIL dc_count: got %0d, required 5", got_d.size()); end
        for (int i = 0; i < got_d.size(); i++) begin
            n_tests++;
            if (got_d[i] != 1000 || got_s[i] !== 1'b0) begin
                n_fail++; $display("FAIL dc_value[%0d]: got %0d sat %0b, required 1000 sat 0", i, got_d[i], got_s[i]);
            end
        end
    endtask

    task automatic test_ramp(input bit lin);
        do_reset();
        send(0, 32768, lin); send(100, 32768, lin); send(200, 32768, lin); send(300, 32768, lin);
        idle();
        wait_outputs(1, 10);
        n_tests++; if (got_d.size() != 1) begin n_fail++; $display("FAIL ramp_count lin=%0b: got %0d, required 1", lin, got_d.size()); end
        if (got_d.size() > 0) begin
            n_tests++;
            if (got_d[0] != 150 || got_s[0] !== 1'b0) begin
                n_fail++; $display("FAIL ramp_value lin=%0b: got %0d sat %0b, required 150 sat 0", lin, got_d[0], got_s[0]);
            end
        end
    endtask

    task automatic test_overshoot();
        do_reset();
        send(-32768, 32768, 1'b0); send(32767, 32768, 1'b0); send(32767, 32768, 1'b0); send(-32768, 32768, 1'b0);
        idle();
        wait_outputs(1, 5);
        n_tests++;
        if (got_d.size() != 1 || got_d[0] != 32767 || got_s[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL overshoot: got count %0d value %0d sat %0b, required 1 / 32767 / 1",
                     got_d.size(), (got_d.size() > 0) ? got_d[0] : 0, (got_d.size() > 0) ? got_s[0] : 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int dv[20];
        int mv[20];
        bit lv[20];
        do_reset();
        for (int i = 0; i < 20; i++) begin
            dv[i] = int'($signed(16'($urandom)));
            mv[i] = int'($urandom_range(0, 65535));
            lv[i] = 1'($urandom_range(0, 1));
        end
        fork
            begin
                for (int i = 0; i < 20; i++) send(dv[i], mv[i], lv[i]);
                idle();
            end
            begin
                int g;
                logic signed [15:0] hold;
                g = 0;
                while (!bus.out_valid && g < 100) begin @(negedge clk); g++; end
                @(posedge clk); #1 bus.out_ready = 1'b0;
                @(negedge clk);
                hold = bus.data_out;
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    n_tests++;
                    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.data_out !== hold) begin
                        n_fail++;
                        $display("FAIL stall_cycle%0d: in_ready %0b out_valid %0b data %0d, required 0 / 1 / %0d",
                                 k, bus.in_ready, bus.out_valid, bus.data_out, hold);
                    end
                end
                @(posedge clk); #1 bus.out_ready = 1'b1;
            end
        join
        wait_outputs(17, 10);
        n_tests++; if (got_d.size() != 17) begin n_fail++; $display("FAIL bp_count: got %0d, required 17", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_tests++;
            if (got_d[i] != exp_d[i] || got_s[i] !== exp_s[i]) begin
                n_fail++; $display("FAIL bp_value[%0d]: got %0d sat %0b, required %0d sat %0b", i, got_d[i], got_s[i], exp_d[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        send(5000, 16384, 1'b0); send(5000, 16384, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.data_in = 16'sd7777; flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; flush = 1'b0;
        clear_all();
        send(0, 32768, 1'b0); send(100, 32768, 1'b0); send(200, 32768, 1'b0);
        idle();
        repeat (10) @(negedge clk);
        n_tests++; if (got_d.size() != 0) begin n_fail++; $display("FAIL flush_priming: got %0d outputs, required 0", got_d.size()); end
        send(300, 32768, 1'b0);
        idle();
        wait_outputs(1, 5);
        n_tests++;
        if (got_d.size() != 1 || got_d[0] != 150) begin
            n_fail++; $display("FAIL flush_first_out: got count %0d value %0d, required 1 / 150",
                               got_d.size(), (got_d.size() > 0) ? got_d[0] : 0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 8; i++) send(1000, 12345, 1'b0);
        idle();
        @(posedge clk);
        #2;
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %0b, required 1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.data_out !== 16'sd0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: out_valid %0b data %0d in_ready %0b, required 0 / 0 / 0",
                               bus.out_valid, bus.data_out, bus.in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_all();
        send(0, 32768, 1'b0); send(100, 32768, 1'b0); send(200, 32768, 1'b0);
        idle();
        repeat (10) @(negedge clk);
        n_tests++; if (got_d.size() != 0) begin n_fail++; $display("FAIL reset_priming: got %0d outputs, required 0", got_d.size()); end
        send(300, 32768, 1'b0);
        idle();
        wait_outputs(1, 5);
        n_tests++;
        if (got_d.size() != 1 || got_d[0] != 150) begin
            n_fail++; $display("FAIL reset_first_out: got count %0d value %0d, required 1 / 150",
                               got_d.size(), (got_d.size() > 0) ? got_d[0] : 0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.data_in = '0; bus.mu_in = '0;
        bus.mode_in = FARROW_CUBIC; bus.out_ready = 1'b1;
        clear_all();
        test_reset();
        test_dc();
        test_ramp(1'b0);
        test_ramp(1'b1);
        test_overshoot();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
